// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-port memory bus arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 32;
    // Width of the ISSUE+WAIT watchdog counter.
    localparam int TO_W       = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the memory unit.
//
// Handshake: a requester raises rN_req with stable addr/data/we and holds it
// until rN_ack pulses for one cycle (rN_err=1 marks a timeout abort, rN_q is
// valid with the ack). Toward memory, mem_start is held high until mem_busy
// has been seen high and then low again; address/data/we are stable meanwhile.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              r0_req;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data;
    logic              r0_we;
    logic              r0_ack;
    logic [DATA_W-1:0] r0_q;
    logic              r0_err;

    logic              r1_req;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;
    logic              r1_we;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_q;
    logic              r1_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_start;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_q;
    logic              mem_initDone;

    logic              grant;
    arb_state_e        state_dbg;

    // Arbiter side.
    modport slave (
        input  r0_req, r0_addr, r0_data, r0_we,
        output r0_ack, r0_q, r0_err,
        input  r1_req, r1_addr, r1_data, r1_we,
        output r1_ack, r1_q, r1_err,
        output mem_address, mem_data, mem_we, mem_start,
        input  mem_busy, mem_q, mem_initDone,
        output grant, state_dbg
    );

    // Requesters plus memory unit side.
    modport master (
        output r0_req, r0_addr, r0_data, r0_we,
        input  r0_ack, r0_q, r0_err,
        output r1_req, r1_addr, r1_data, r1_we,
        input  r1_ack, r1_q, r1_err,
        input  mem_address, mem_data, mem_we, mem_start,
        output mem_busy, mem_q, mem_initDone,
        input  grant, state_dbg
    );

endinterface

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Combinational two-way picker: fixed priority to port 0, or round-robin
// where a tie goes to the port that was not served last.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       win,
    output logic       valid
);

    // Pick a winner from the current request vector.
    always_comb begin
        valid = |req;
        win   = 1'b0;
        if (fixed_prio) begin
            win = ~req[0] & req[1];
        end else if (req == 2'b11) begin
            win = ~last;
        end else begin
            win = req[1];
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sequencing grants through the memory unit's
// start/busy/q handshake, with a watchdog that aborts a stalled access.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = 1023,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);

    localparam logic            FIXED   = (FIXED_PRIO != 0);
    // Abort fires on the edge where the count would reach TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_e        state;
    logic [TO_W-1:0]   cnt;
    logic              last;

    logic [1:0]        req_vec;
    logic              pick_win;
    logic              pick_valid;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;
    logic              pick_we;

    logic              fin;
    logic              fin_err;
    logic [DATA_W-1:0] fin_q;

    assign req_vec       = {bus.r1_req, bus.r0_req};
    assign bus.state_dbg = state;

    arb_rr2 u_pick (
        .req        (req_vec),
        .last       (last),
        .fixed_prio (FIXED),
        .win        (pick_win),
        .valid      (pick_valid)
    );

    // Route the winner's request fields toward the memory latch.
    always_comb begin
        pick_addr = bus.r0_addr;
        pick_data = bus.r0_data;
        pick_we   = bus.r0_we;
        if (pick_win) begin
            pick_addr = bus.r1_addr;
            pick_data = bus.r1_data;
            pick_we   = bus.r1_we;
        end
    end

    // Decide whether the current access ends this edge, and how.
    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_q   = '0;
        if (state == WAIT && !bus.mem_busy) begin
            fin   = 1'b1;
            fin_q = bus.mem_q;
        end else if ((state == ISSUE || state == WAIT) && cnt == TO_LAST) begin
            fin     = 1'b1;
            fin_err = 1'b1;
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            last            <= 1'b1;
            bus.grant       <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data    <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_start   <= 1'b0;
            bus.r0_ack      <= 1'b0;
            bus.r0_err      <= 1'b0;
            bus.r0_q        <= '0;
            bus.r1_ack      <= 1'b0;
            bus.r1_err      <= 1'b0;
            bus.r1_q        <= '0;
        end else begin
            bus.r0_ack <= 1'b0;
            bus.r0_err <= 1'b0;
            bus.r1_ack <= 1'b0;
            bus.r1_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A slave still busy after an abort keeps the bus closed.
                    if (bus.mem_initDone && !bus.mem_busy && pick_valid) begin
                        bus.mem_address <= pick_addr;
                        bus.mem_data    <= pick_data;
                        bus.mem_we      <= pick_we;
                        bus.mem_start   <= 1'b1;
                        bus.grant       <= pick_win;
                        last            <= pick_win;
                        cnt             <= '0;
                        state           <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (fin) begin
                        // Dropping start here keeps the slave from starting a
                        // second access on the following negedge.
                        bus.mem_start <= 1'b0;
                        state         <= IDLE;
                        if (bus.grant) begin
                            bus.r1_ack <= 1'b1;
                            bus.r1_err <= fin_err;
                            bus.r1_q   <= fin_q;
                        end else begin
                            bus.r0_ack <= 1'b1;
                            bus.r0_err <= fin_err;
                            bus.r0_q   <= fin_q;
                        end
                    end else if (state == ISSUE && bus.mem_busy) begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
